// File: rtl/fixed_point_delta_decoder.sv
// Streaming fixed-point delta decoder.
// Rebuilds absolute Q(WIO.WFO) samples from signed Q(WI.WF) differences by
// running accumulation. The output is a single registered stage with a
// valid/ready handshake on both sides, giving full throughput.
// Optional feature macro: DELTA_DEC_SATURATE_EN. When it is defined, an
// overflowing result clamps to the format limit. When it is undefined, the
// result wraps in two's complement.
module fixed_point_delta_decoder #(
    parameter int WI   = 4,
    parameter int WF   = 4,
    parameter int WIO  = 8,
    parameter int WFO  = 4,
    parameter int CNTW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WI+WF-1:0]       delta_in,
    input  logic                   first,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIO+WFO-1:0]     sample_out,
    output logic                   overFlow,
    output logic [CNTW-1:0]        sample_cnt
);

    localparam int OW = WIO + WFO;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                 state_q, state_d;
    // The output register doubles as the running accumulator: both are
    // loaded with the same value on every accept and cleared by reset.
    logic signed [OW-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;

    logic                   accept;
    logic                   consume;
    logic signed [WI+WF-1:0] delta_s;
    logic signed [OW:0]     delta_ext;
    logic signed [OW:0]     aligned;
    logic signed [OW:0]     acc_ext;
    logic signed [OW:0]     next_val;
    logic                   ovf;

`ifdef DELTA_DEC_SATURATE_EN
    // Clamp to the signed format limit when the extended sum left the range.
    function automatic logic [OW-1:0] limit_result(input logic signed [OW:0] v,
                                                   input logic ovf_flag);
        logic [OW-1:0] r;
        if (ovf_flag) begin
            r = v[OW] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end else begin
            r = v[OW-1:0];
        end
        return r;
    endfunction
`else
    // Two's-complement wrap: drop the guard bit.
    function automatic logic [OW-1:0] limit_result(input logic signed [OW:0] v,
                                                   input logic ovf_flag);
        logic unused_flag;
        unused_flag = ovf_flag;
        return v[OW-1:0];
    endfunction
`endif

    // Handshake: the single output register can take new data whenever it is
    // empty or being drained in this same cycle.
    always_comb begin
        in_ready = (state_q == EMPTY) || out_ready;
        accept   = in_valid && in_ready;
        consume  = (state_q == FULL) && out_ready;
    end

    // Datapath: align the delta to the output fraction, add to the
    // accumulator (or reseed on a key sample) and detect overflow from the
    // guard bit.
    always_comb begin
        delta_s   = delta_in;
        delta_ext = (OW+1)'(delta_s);
        aligned   = delta_ext <<< (WFO - WF);
        acc_ext   = {acc_q[OW-1], acc_q};
        next_val  = first ? aligned : (acc_ext + aligned);
        ovf       = next_val[OW] ^ next_val[OW-1];
    end

    // Next-state logic for the output register, sample counter and FSM.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (accept) begin
            acc_d = limit_result(next_val, ovf);
            ovf_d = ovf;
            cnt_d = first ? CNTW'(1) : (cnt_q + CNTW'(1));
        end
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (consume && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // State registers; reset also discards any pending output sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign sample_out = acc_q;
    assign overFlow   = ovf_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_fixed_point_delta_decoder.sv
// Scoreboard bench for fixed_point_delta_decoder with an arithmetic reference
// model. Set DELTA_DEC_SATURATE_EN to match the DUT build.
module tb_fixed_point_delta_decoder;

    localparam int WI = 4, WF = 4, WIO = 8, WFO = 4, CNTW = 8;
    localparam int OW = WIO + WFO;
    localparam int DW = WI + WF;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   delta_in = '0;
    logic            first = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [OW-1:0]   sample_out;
    logic            overFlow;
    logic [CNTW-1:0] sample_cnt;

    fixed_point_delta_decoder #(.WI(WI), .WF(WF), .WIO(WIO), .WFO(WFO), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .delta_in(delta_in), .first(first), .out_valid(out_valid),
        .out_ready(out_ready), .sample_out(sample_out), .overFlow(overFlow),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0]   s;
        logic            o;
        logic [CNTW-1:0] c;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   acc_m = 0;
    int   cnt_m = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Reference: real-valued accumulation in units of 2^-WFO, then range check.
    function automatic exp_t model_step(input logic f, input logic [DW-1:0] d_raw);
        exp_t e;
        logic signed [DW-1:0] ds;
        int d, nxt, mx, mn, r;
        ds  = d_raw;
        d   = int'(ds) * (1 << (WFO - WF));
        nxt = f ? d : acc_m + d;
        mx  = (1 << (OW - 1)) - 1;
        mn  = -(1 << (OW - 1));
        e.o = (nxt > mx) || (nxt < mn);
`ifdef DELTA_DEC_SATURATE_EN
        r = (nxt > mx) ? mx : (nxt < mn) ? mn : nxt;
`else
        r = nxt & ((1 << OW) - 1);
        if (r > mx) r = r - (1 << OW);
`endif
        acc_m = r;
        cnt_m = f ? 1 : (cnt_m + 1) % (1 << CNTW);
        e.s = OW'(r);
        e.c = CNTW'(cnt_m);
        return e;
    endfunction

    // Monitor: samples mid-cycle; handshakes seen here complete at the next edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            acc_m = 0;
            cnt_m = 0;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
            if (out_valid && q.size() != 0) begin
                chk("sample_out", 32'(sample_out), 32'(q[0].s));
                chk("overFlow", 32'(overFlow), 32'(q[0].o));
                chk("sample_cnt", 32'(sample_cnt), 32'(q[0].c));
            end
            if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && in_ready) q.push_back(model_step(first, delta_in));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic f, input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        first = f;
        delta_in = d;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            cyc();
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no accept want accept at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sample_out", 32'(sample_out), 32'h0);
        chk("rst_cnt", 32'(sample_cnt), 32'h0);
        chk("rst_ovf", 32'(overFlow), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        cyc();

        // Basic decode: 0x010, 0x018, 0x008
        send(1'b1, 8'h10);
        send(1'b0, 8'h08);
        send(1'b0, 8'hF0);
        idle(2);

        // Reseed mid-stream from 0x018
        send(1'b1, 8'h10);
        send(1'b0, 8'h08);
        send(1'b1, 8'hC0);
        idle(2);

        // Positive overflow, then one step down
        send(1'b1, 8'h7F);
        repeat (16) send(1'b0, 8'h7F);
        send(1'b0, 8'hF0);
        idle(2);

        // Reach -128.0 then step negative
        send(1'b1, 8'h80);
        repeat (15) send(1'b0, 8'h80);
        send(1'b0, 8'hF0);
        idle(2);

        // Backpressure: held output with a pending input for 5 cycles
        out_ready = 1'b0;
        send(1'b1, 8'h10);
        first = 1'b0;
        delta_in = 8'h08;
        in_valid = 1'b1;
        repeat (5) cyc();
        out_ready = 1'b1;
        repeat (6) send(1'b0, 8'h08);
        idle(2);

        // Reset while a stalled sample is pending
        out_ready = 1'b0;
        send(1'b1, 8'h20);
        idle(2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_cnt", 32'(sample_cnt), 32'h0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
        cyc();
        out_ready = 1'b1;
        send(1'b0, 8'h08);
        idle(2);

        // Randomised traffic with random backpressure and rare resets
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            first     = ($urandom_range(0, 7) == 0);
            delta_in  = DW'($urandom);
            rst       = ($urandom_range(0, 255) == 0);
            cyc();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("drain_empty", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
